queue_bcd_scan: RTL

//  Upstream stage of the 7-segment decoder in the queue display path.

---
 rtl/queue_bcd_scan.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/queue_bcd_scan.sv
// Queue head-count: two sensor lines feed a saturating 2-digit BCD counter,
// which is time-multiplexed onto a single 4-bit digit bus with one-hot enables.
module queue_bcd_scan #(
   parameter int REFRESH_DIV = 50000,
   parameter int MAX_COUNT   = 99,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc_in,
   input  logic       dec_in,
   input  logic       clr,
   output logic       dig_a,
   output logic       dig_b,
   output logic       dig_c,
   output logic       dig_d,
   output logic [1:0] digit_en,
   output logic [7:0] count_bcd,
   output logic       full,
   output logic       empty
);

   localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] TERM     = CW'(REFRESH_DIV - 1);
   localparam logic [7:0]    MAX_BCD  = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end else begin
         return {v[7:4], v[3:0] + 4'd1};
      end
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) begin
         return {v[7:4] - 4'd1, 4'd9};
      end else begin
         return {v[7:4], v[3:0] - 4'd1};
      end
   endfunction

   logic          inc_s1_r, inc_s2_r, inc_s3_r;
   logic          dec_s1_r, dec_s2_r, dec_s3_r;
   logic          inc_edge_s, dec_edge_s;
   logic [7:0]    count_r, count_next_s;
   logic          full_r, empty_r;
   logic [CW-1:0] refresh_r, refresh_next_s;
   logic          sel_r, sel_next_s;
   logic [3:0]    dig_r, dig_next_s;
   logic [1:0]    en_r, en_next_s;

   assign inc_edge_s = inc_s2_r & ~inc_s3_r;
   assign dec_edge_s = dec_s2_r & ~dec_s3_r;

   // Two-flop synchronizers plus one history flop per sensor for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inc_s1_r <= 1'b0;
         inc_s2_r <= 1'b0;
         inc_s3_r <= 1'b0;
         dec_s1_r <= 1'b0;
         dec_s2_r <= 1'b0;
         dec_s3_r <= 1'b0;
      end else begin
         inc_s1_r <= inc_in;
         inc_s2_r <= inc_s1_r;
         inc_s3_r <= inc_s2_r;
         dec_s1_r <= dec_in;
         dec_s2_r <= dec_s1_r;
         dec_s3_r <= dec_s2_r;
      end
   end

   // Next count: clear wins, coincident edges cancel, otherwise saturate at either end
   always_comb begin
      count_next_s = count_r;
      if (clr) begin
         count_next_s = 8'h00;
      end else if (inc_edge_s && dec_edge_s) begin
         count_next_s = count_r;
      end else if (inc_edge_s) begin
         if (count_r == MAX_BCD) begin
            count_next_s = count_r;
         end else begin
            count_next_s = bcd_inc(count_r);
         end
      end else if (dec_edge_s) begin
         if (count_r == 8'h00) begin
            count_next_s = count_r;
         end else begin
            count_next_s = bcd_dec(count_r);
         end
      end else begin
         count_next_s = count_r;
      end
   end

   // Slot timer: sel flips on the cycle the refresh counter wraps
   always_comb begin
      refresh_next_s = refresh_r;
      sel_next_s     = sel_r;
      if (refresh_r == TERM) begin
         refresh_next_s = '0;
         sel_next_s     = ~sel_r;
      end else begin
         refresh_next_s = refresh_r + CW'(1);
         sel_next_s     = sel_r;
      end
   end

   // Digit bus and enable derive from next-state values so both move on one edge
   always_comb begin
      dig_next_s = count_next_s[3:0];
      en_next_s  = 2'b01;
      case (sel_next_s)
         1'b0: begin
            dig_next_s = count_next_s[3:0];
            en_next_s  = 2'b01;
         end
         1'b1: begin
            dig_next_s = count_next_s[7:4];
            if (BLANK_LZ && (count_next_s[7:4] == 4'd0)) begin
               en_next_s = 2'b00;
            end else begin
               en_next_s = 2'b10;
            end
         end
         default: begin
            dig_next_s = 4'h0;
            en_next_s  = 2'b00;
         end
      endcase
   end

   // Count, flags, scan state and display registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r   <= 8'h00;
         full_r    <= 1'b0;
         empty_r   <= 1'b1;
         refresh_r <= '0;
         sel_r     <= 1'b0;
         dig_r     <= 4'h0;
         en_r      <= 2'b01;
      end else begin
         count_r   <= count_next_s;
         full_r    <= (count_next_s == MAX_BCD);
         empty_r   <= (count_next_s == 8'h00);
         refresh_r <= refresh_next_s;
         sel_r     <= sel_next_s;
         dig_r     <= dig_next_s;
         en_r      <= en_next_s;
      end
   end

   assign {dig_a, dig_b, dig_c, dig_d} = dig_r;
   assign digit_en  = en_r;
   assign count_bcd = count_r;
   assign full      = full_r;
   assign empty     = empty_r;

endmodule
